// File: rtl/la_pkg.sv
// la_pkg: engine state encodings and UART constants shared by the transmit path
// and the host-side decoder model.
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_SYNC,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_DONE,
        ST_RELEASE
    } txd_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
    localparam int         CLK_HZ           = 50_000_000;
    localparam int         BAUD             = 115_200;
    localparam int         CLKS_PER_BIT_DEF = CLK_HZ / BAUD;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser; one character per accepted start, ready while idle.
module uart_tx_byte
    import la_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_busy;
    logic             r_tx;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic [7:0]       r_shift;

    // r_idx 0 is the start bit, 1..8 data, 9 stop; ready returns when the stop period ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else if (!r_busy) begin
            if (start) begin
                r_busy  <= 1'b1;
                r_tx    <= 1'b0;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_shift <= data;
            end
        end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt   <= '0;
            r_idx   <= r_idx + 1'b1;
            r_tx    <= (r_idx >= 4'd8) ? 1'b1 : r_shift[0];
            r_shift <= r_shift >> 1;
            r_busy  <= r_idx != 4'd9;
        end
    end

    assign tx    = r_tx;
    assign ready = !r_busy;

endmodule

// File: rtl/txd_engine.sv
// txd_engine: streams a sync byte plus the whole sample RAM over UART while the
// dispatcher grants the transmit task, then pulses done_txd.
module txd_engine
    import la_pkg::*;
#(
    parameter int         ADDR_W       = 10,
    parameter int         DEPTH        = 1024,
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant_txd,
    output logic              done_txd,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    txd_state_t        r_state;
    txd_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_sent;
    logic              w_start;
    logic              w_ready;
    logic              w_last;
    logic [7:0]        w_data;

    assign w_last  = r_addr == LAST;
    assign rd_addr = r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // r_sent remembers that the sync character was accepted, so SEND_SYNC waits for its end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_sent <= 1'b0;
        end else begin
            r_sent <= (r_state == ST_SEND_SYNC) && (r_sent || (w_start && w_ready));
            if (r_state == ST_IDLE && grant_txd)
                r_addr <= '0;
            else if (r_state == ST_SEND && w_ready && grant_txd && !w_last)
                r_addr <= r_addr + 1'b1;
        end
    end

    // a dropped grant lets the character in flight finish, then falls back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (grant_txd) w_next = ST_SEND_SYNC;
            ST_SEND_SYNC: if (r_sent && w_ready) w_next = grant_txd ? ST_FETCH : ST_IDLE;
                          else if (!r_sent && !grant_txd) w_next = ST_IDLE;
            ST_FETCH:     w_next = grant_txd ? ST_LOAD : ST_IDLE;
            ST_LOAD:      w_next = grant_txd ? ST_SEND : ST_IDLE;
            ST_SEND:      if (w_ready) w_next = !grant_txd ? ST_IDLE : w_last ? ST_DONE : ST_FETCH;
            ST_DONE:      w_next = ST_RELEASE;
            ST_RELEASE:   if (!grant_txd) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = r_state != ST_IDLE;
        done_txd = r_state == ST_DONE;
        rd_en    = (r_state == ST_FETCH) && grant_txd;
        w_start  = grant_txd && (((r_state == ST_SEND_SYNC) && !r_sent) || (r_state == ST_LOAD));
        w_data   = (r_state == ST_SEND_SYNC) ? SYNC_BYTE : rd_data;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .rst  (rst),
        .start(w_start),
        .data (w_data),
        .tx   (tx),
        .ready(w_ready)
    );

endmodule
